// File: rtl/dmem_port_arbiter.sv
// Two-port round-robin sequencer in front of a word-wide data memory without byte enables.
// Handles RV32I load formatting, read-modify-write sub-word stores and access-fault rejection.
module dmem_port_arbiter #(
    parameter int MEM_WORDS = 131072,
    parameter int ADDR_W    = 17
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rq0_valid,
    output logic              rq0_ready,
    input  logic              rq0_we,
    input  logic [2:0]        rq0_funct3,
    input  logic [31:0]       rq0_addr,
    input  logic [31:0]       rq0_wdata,
    input  logic              rq1_valid,
    output logic              rq1_ready,
    input  logic              rq1_we,
    input  logic [2:0]        rq1_funct3,
    input  logic [31:0]       rq1_addr,
    input  logic [31:0]       rq1_wdata,
    output logic              rsp0_valid,
    output logic              rsp1_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [2:0] {IDLE, RD, CAP, WR, RSP} state_t;

    state_t             state_q, state_d;
    logic               rr_q, have_q;
    logic               port_q, we_q, err_q;
    logic [2:0]         f3_q;
    logic [1:0]         lo_q;
    logic [31:0]        rdata_q;
    logic [ADDR_W-1:0]  mem_addr_q;
    logic [31:0]        mem_wdata_q;

    logic               sel, hs;
    logic               s_we, s_err;
    logic [2:0]         s_f3;
    logic [31:0]        s_addr, s_wdata;
    logic               unused_bits;

    function automatic logic is_illegal(input logic [2:0] f3, input logic we, input logic [1:0] lo);
        case (f3)
            3'b000:  return 1'b0;
            3'b001:  return lo[0];
            3'b010:  return lo != 2'b00;
            3'b100:  return we;
            3'b101:  return we | lo[0];
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] load_fmt(input logic [31:0] w, input logic [2:0] f3, input logic [1:0] lo);
        logic [31:0] sh;
        logic [7:0]  b;
        logic [15:0] h;
        sh = w >> {lo, 3'b000};
        b  = sh[7:0];
        h  = lo[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'b0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'b0, h};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [31:0] wd,
                                                input logic [2:0] f3, input logic [1:0] lo);
        logic [31:0] r;
        r = w;
        if (f3[1:0] == 2'b00) begin
            case (lo)
                2'b00:   r[7:0]   = wd[7:0];
                2'b01:   r[15:8]  = wd[7:0];
                2'b10:   r[23:16] = wd[7:0];
                default: r[31:24] = wd[7:0];
            endcase
        end else if (lo[1]) begin
            r[31:16] = wd[15:0];
        end else begin
            r[15:0] = wd[15:0];
        end
        return r;
    endfunction

    // Tie goes to the port not granted last; port 0 wins until the first grant is made.
    always_comb begin
        if (rq0_valid && rq1_valid) sel = have_q && !rr_q;
        else                        sel = rq1_valid;
    end

    assign s_we    = sel ? rq1_we     : rq0_we;
    assign s_f3    = sel ? rq1_funct3 : rq0_funct3;
    assign s_addr  = sel ? rq1_addr   : rq0_addr;
    assign s_wdata = sel ? rq1_wdata  : rq0_wdata;
    assign s_err   = is_illegal(s_f3, s_we, s_addr[1:0]);
    assign hs      = rq0_ready | rq1_ready;

    // Address bits above the memory depth wrap around.
    assign unused_bits = (^s_addr[31:ADDR_W+2]) ^ (MEM_WORDS == 0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            have_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (hs) begin
                rr_q   <= sel;
                have_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (hs) begin
                    if (s_err)                    state_d = RSP;
                    else if (!s_we)               state_d = RD;
                    else if (s_f3[1:0] == 2'b10)  state_d = WR;
                    else                          state_d = RD;
                end
            end
            RD:      state_d = CAP;
            CAP:     state_d = we_q ? WR : RSP;
            WR:      state_d = RSP;
            RSP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rq0_ready  = 1'b0;
        rq1_ready  = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        rsp_rdata  = 32'b0;
        rsp_err    = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        if (!reset) begin
            rq0_ready  = (state_q == IDLE) && rq0_valid && !sel;
            rq1_ready  = (state_q == IDLE) && rq1_valid && sel;
            rsp0_valid = (state_q == RSP) && !port_q;
            rsp1_valid = (state_q == RSP) && port_q;
            rsp_rdata  = (state_q == RSP) ? rdata_q : 32'b0;
            rsp_err    = (state_q == RSP) && err_q;
            mem_en     = (state_q == RD) || (state_q == WR);
            mem_we     = (state_q == WR);
        end
    end

    always_ff @(posedge clk) begin
        if (hs) begin
            port_q  <= sel;
            we_q    <= s_we;
            f3_q    <= s_f3;
            lo_q    <= s_addr[1:0];
            err_q   <= s_err;
            rdata_q <= 32'b0;
        end else if (state_q == CAP && !we_q) begin
            rdata_q <= load_fmt(mem_rdata, f3_q, lo_q);
        end
    end

    // mem_wdata doubles as the store-data latch until CAP overwrites it with the merged word.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'b0;
        end else if (hs) begin
            mem_addr_q  <= s_addr[ADDR_W+1:2];
            mem_wdata_q <= s_wdata;
        end else if (state_q == CAP && we_q) begin
            mem_wdata_q <= store_merge(mem_rdata, mem_wdata_q, f3_q, lo_q);
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a behavioural DMEM model and strobe counters.
module tb_dmem_port_arbiter;
    localparam int ADDR_W = 17;

    logic clk = 1'b0;
    logic reset;
    logic rq0_valid, rq0_ready, rq0_we, rq1_valid, rq1_ready, rq1_we;
    logic [2:0] rq0_funct3, rq1_funct3;
    logic [31:0] rq0_addr, rq0_wdata, rq1_addr, rq1_wdata;
    logic rsp0_valid, rsp1_valid, rsp_err, mem_en, mem_we;
    logic [31:0] rsp_rdata, mem_wdata, mem_rdata;
    logic [ADDR_W-1:0] mem_addr;

    logic [31:0] mem [0:131071];
    logic pre_en;
    logic [ADDR_W-1:0] pre_addr;
    logic [31:0] pre_data;
    int en_cnt = 0, we_cnt = 0, r0_cnt = 0, r1_cnt = 0;
    int vectors = 0, miscompares = 0;

    always #5 clk = ~clk;

    dmem_port_arbiter #(.MEM_WORDS(131072), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset),
        .rq0_valid(rq0_valid), .rq0_ready(rq0_ready), .rq0_we(rq0_we), .rq0_funct3(rq0_funct3),
        .rq0_addr(rq0_addr), .rq0_wdata(rq0_wdata),
        .rq1_valid(rq1_valid), .rq1_ready(rq1_ready), .rq1_we(rq1_we), .rq1_funct3(rq1_funct3),
        .rq1_addr(rq1_addr), .rq1_wdata(rq1_wdata),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always @(posedge clk) begin
        if (pre_en) mem[pre_addr] <= pre_data;
        else if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            mem_rdata <= mem[mem_addr];
        end
        if (mem_en)            en_cnt <= en_cnt + 1;
        if (mem_en && mem_we)  we_cnt <= we_cnt + 1;
        if (rsp0_valid)        r0_cnt <= r0_cnt + 1;
        if (rsp1_valid)        r1_cnt <= r1_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [ADDR_W-1:0] wa, input logic [31:0] d);
        @(negedge clk);
        pre_en = 1'b1; pre_addr = wa; pre_data = d;
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    task automatic drive(input int p, input logic v, input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        if (p == 0) begin
            rq0_valid = v; rq0_we = we; rq0_funct3 = f3; rq0_addr = a; rq0_wdata = wd;
        end else begin
            rq1_valid = v; rq1_we = we; rq1_funct3 = f3; rq1_addr = a; rq1_wdata = wd;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Handshake cycle is T; lat = cycles from T to the owner's rsp pulse (-1 if none within 8).
    task automatic req(input string tag, input int p, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       output int lat, output logic [31:0] rd, output logic er);
        int w;
        logic rdy;
        lat = -1; rd = 32'b0; er = 1'b0;
        @(negedge clk);
        drive(p, 1'b1, we, f3, a, wd);
        #1;
        w = 0;
        rdy = (p == 0) ? rq0_ready : rq1_ready;
        while (!rdy && w < 20) begin
            @(negedge clk); #1; w++;
            rdy = (p == 0) ? rq0_ready : rq1_ready;
        end
        if (!rdy) begin
            chk({tag, "_accept"}, {31'b0, rdy}, 32'd1);
            drive(p, 1'b0, we, f3, a, wd);
            return;
        end
        @(negedge clk);
        drive(p, 1'b0, we, f3, a, wd);
        for (int k = 1; k <= 8; k++) begin
            #1;
            if ((p == 0) ? rsp0_valid : rsp1_valid) begin
                lat = k; rd = rsp_rdata; er = rsp_err;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat, e0, w0, b0, b1, ng;
        logic [31:0] rd;
        logic er;
        int gnt [4];
        int        ep [4];
        logic      ew [4];
        logic [2:0] ef [4];
        logic [31:0] ea [4];

        reset = 1'b1; pre_en = 1'b0; pre_addr = '0; pre_data = '0;
        drive(0, 1'b0, 1'b0, 3'b0, 32'b0, 32'b0);
        drive(1, 1'b0, 1'b0, 3'b0, 32'b0, 32'b0);
        repeat (3) @(negedge clk);

        rq0_valid = 1'b1; rq1_valid = 1'b1;
        #1;
        chk("rst_ready0", {31'b0, rq0_ready}, 32'd0);
        chk("rst_ready1", {31'b0, rq1_ready}, 32'd0);
        chk("rst_mem_en", {31'b0, mem_en}, 32'd0);
        chk("rst_rsp", {30'b0, rsp1_valid, rsp0_valid}, 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_err", {31'b0, rsp_err}, 32'd0);
        chk("rst_mem_addr", {15'b0, mem_addr}, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        @(negedge clk);
        rq0_valid = 1'b0; rq1_valid = 1'b0; reset = 1'b0;

        preload(17'd5, 32'h8000_00F0);
        preload(17'd2, 32'h1122_3344);

        req("lw", 0, 1'b0, 3'b010, 32'h14, 32'h0, lat, rd, er);
        chk("lw_lat", lat, 32'd3);
        chk("lw_data", rd, 32'h8000_00F0);
        chk("lw_err", {31'b0, er}, 32'd0);
        req("lb", 0, 1'b0, 3'b000, 32'h14, 32'h0, lat, rd, er);
        chk("lb_data", rd, 32'hFFFF_FFF0);
        req("lbu", 1, 1'b0, 3'b100, 32'h14, 32'h0, lat, rd, er);
        chk("lbu_data", rd, 32'h0000_00F0);
        req("lh", 1, 1'b0, 3'b001, 32'h16, 32'h0, lat, rd, er);
        chk("lh_lat", lat, 32'd3);
        chk("lh_data", rd, 32'hFFFF_8000);
        req("lhu", 0, 1'b0, 3'b101, 32'h16, 32'h0, lat, rd, er);
        chk("lhu_data", rd, 32'h0000_8000);

        e0 = en_cnt;
        req("sb", 0, 1'b1, 3'b000, 32'h09, 32'h0000_00AB, lat, rd, er);
        chk("sb_lat", lat, 32'd4);
        chk("sb_rdata", rd, 32'd0);
        chk("sb_strobes", en_cnt - e0, 32'd2);
        chk("sb_mem", mem[2], 32'h1122_AB44);
        req("sh", 1, 1'b1, 3'b001, 32'h0A, 32'h0000_BEEF, lat, rd, er);
        chk("sh_lat", lat, 32'd4);
        chk("sh_mem", mem[2], 32'hBEEF_AB44);
        e0 = en_cnt; w0 = we_cnt;
        req("sw", 0, 1'b1, 3'b010, 32'h0C, 32'hCAFE_BABE, lat, rd, er);
        chk("sw_lat", lat, 32'd2);
        chk("sw_en_strobes", en_cnt - e0, 32'd1);
        chk("sw_we_strobes", we_cnt - w0, 32'd1);
        chk("sw_mem", mem[3], 32'hCAFE_BABE);
        req("lw_wrap", 1, 1'b0, 3'b010, 32'h0008_0008, 32'h0, lat, rd, er);
        chk("lw_wrap_data", rd, 32'hBEEF_AB44);

        ep[0] = 0; ew[0] = 1'b0; ef[0] = 3'b010; ea[0] = 32'h02;
        ep[1] = 1; ew[1] = 1'b1; ef[1] = 3'b001; ea[1] = 32'h01;
        ep[2] = 0; ew[2] = 1'b0; ef[2] = 3'b011; ea[2] = 32'h10;
        ep[3] = 1; ew[3] = 1'b1; ef[3] = 3'b100; ea[3] = 32'h10;
        for (int i = 0; i < 4; i++) begin
            e0 = en_cnt;
            req($sformatf("err%0d", i), ep[i], ew[i], ef[i], ea[i], 32'hFFFF_FFFF, lat, rd, er);
            chk($sformatf("err%0d_lat", i), lat, 32'd1);
            chk($sformatf("err%0d_flag", i), {31'b0, er}, 32'd1);
            chk($sformatf("err%0d_rdata", i), rd, 32'd0);
            chk($sformatf("err%0d_no_strobe", i), en_cnt - e0, 32'd0);
        end

        // Both ports requesting continuously: grants must alternate starting with port 0.
        do_reset();
        b0 = r0_cnt; b1 = r1_cnt; ng = 0;
        drive(0, 1'b1, 1'b0, 3'b010, 32'h14, 32'h0);
        drive(1, 1'b1, 1'b0, 3'b010, 32'h14, 32'h0);
        for (int c = 0; c < 40 && ng < 4; c++) begin
            #1;
            if (rq0_ready) begin gnt[ng] = 0; ng++; end
            else if (rq1_ready) begin gnt[ng] = 1; ng++; end
            if (ng < 4) @(negedge clk);
        end
        @(negedge clk);
        rq0_valid = 1'b0; rq1_valid = 1'b0;
        chk("arb_grants", ng, 32'd4);
        for (int i = 0; i < ng; i++) chk($sformatf("arb_grant%0d", i), gnt[i], i % 2);
        repeat (6) @(negedge clk);
        chk("arb_rsp0_count", r0_cnt - b0, 32'd2);
        chk("arb_rsp1_count", r1_cnt - b1, 32'd2);

        // Reset during the RD cycle of an SB: nothing reaches memory, no response.
        e0 = en_cnt; w0 = we_cnt; b0 = r0_cnt; b1 = r1_cnt;
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 3'b000, 32'h09, 32'h0000_0055);
        #1;
        chk("mid_accept", {31'b0, rq0_ready}, 32'd1);
        @(negedge clk);
        rq0_valid = 1'b0; reset = 1'b1;
        #1;
        chk("mid_en_gated", {31'b0, mem_en}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        rq1_valid = 1'b1; rq1_we = 1'b0; rq1_funct3 = 3'b010; rq1_addr = 32'h08;
        #1;
        chk("mid_ready_after", {31'b0, rq1_ready}, 32'd1);
        rq1_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid_no_strobe", en_cnt - e0, 32'd0);
        chk("mid_no_write", we_cnt - w0, 32'd0);
        chk("mid_no_rsp", (r0_cnt - b0) + (r1_cnt - b1), 32'd0);
        chk("mid_mem", mem[2], 32'hBEEF_AB44);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
